// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : pixel_unpacker
// Description : Streams NPIX packed pixels per input word out one per cycle,
//               pixel 0 (MSBs) first, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_unpacker #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [PIX_W*NPIX-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [PIX_W-1:0]      out_pix,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [15:0]           pix_count
);

    localparam int c_WORD_W = PIX_W * NPIX;
    localparam int c_IDX_W  = $clog2(NPIX);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NPIX - 1);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_HOLD  = 1'b1;

    logic [c_WORD_W-1:0] r_word;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_last;
    logic [0:0]          r_state;
    logic [15:0]         r_pix_count;

    logic                w_hold;
    logic                w_idx_last;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [PIX_W-1:0]    w_pix [NPIX];

    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi = gi + 1) begin : g_slice
            assign w_pix[gi] = r_word[c_WORD_W-1-PIX_W*gi -: PIX_W];
        end
    endgenerate

    assign w_hold     = (r_state == c_HOLD);
    assign w_idx_last = (r_idx == c_IDX_LAST);

    // Ready is combinational from out_ready so the next word can load on the
    // same edge the final pixel leaves, giving bubble-free word transitions.
    assign in_ready   = !w_hold || (out_ready && w_idx_last);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_hold && out_ready;

    assign out_valid  = w_hold;
    assign out_pix    = w_pix[r_idx];
    assign out_last   = r_last && w_idx_last && w_hold;
    assign pix_count  = r_pix_count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= c_EMPTY;
            r_word      <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_pix_count <= '0;
        end else begin
            if (!w_hold) begin
                if (w_in_fire) begin
                    r_word  <= in_data;
                    r_last  <= in_last;
                    r_idx   <= '0;
                    r_state <= c_HOLD;
                end
            end else if (w_out_fire) begin
                if (!w_idx_last) begin
                    r_idx <= r_idx + 1'b1;
                end else if (w_in_fire) begin
                    r_word <= in_data;
                    r_last <= in_last;
                    r_idx  <= '0;
                end else begin
                    r_state <= c_EMPTY;
                end
            end

            if (w_out_fire) begin
                r_pix_count <= out_last ? 16'd0 : r_pix_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_unpacker
// Description : Self-checking bench for pixel_unpacker (vector table, hand
//               sequences, randomized traffic against a pixel-queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_unpacker;

    logic        clk;
    logic        n_rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_pix;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] pix_count;

    pixel_unpacker #(.PIX_W(8), .NPIX(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .pix_count (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the pixels still owed downstream, in order.
    typedef struct {
        logic [7:0] pix;
        logic       last;
    } ent_t;
    ent_t        m_q[$];
    logic [15:0] m_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic        v;
        logic        l;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic        e_ol;
        logic        chk_pix;
        logic [7:0]  e_pix;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tv[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model.
    task automatic tick();
        logic        m_ir;
        logic        ofire;
        logic        ifire;
        logic [31:0] cap_data;
        logic        cap_last;
        @(negedge clk);
        m_ir = (m_q.size() == 0) || (out_ready && m_q.size() == 1);
        if (n_rst) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_ir});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("m_out_pix", {24'd0, out_pix}, {24'd0, m_q[0].pix});
                chk("m_out_last", {31'd0, out_last}, {31'd0, m_q[0].last});
            end else begin
                chk("m_out_last_idle", {31'd0, out_last}, 32'd0);
            end
            chk("m_pix_count", {16'd0, pix_count}, {16'd0, m_cnt});
        end
        ofire    = (m_q.size() != 0) && out_ready;
        ifire    = in_valid && m_ir;
        cap_data = in_data;
        cap_last = in_last;
        @(posedge clk);
        if (!n_rst) begin
            m_q.delete();
            m_cnt = 16'd0;
        end else begin
            if (ofire) begin
                m_cnt = m_q[0].last ? 16'd0 : m_cnt + 16'd1;
                void'(m_q.pop_front());
            end
            if (ifire) begin
                for (int i = 0; i < 4; i++) begin
                    ent_t e;
                    e.pix  = cap_data[31-8*i -: 8];
                    e.last = cap_last && (i == 3);
                    m_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        //          data          v    l    ordy ir   ov   ol   cpix pix    cnt
        tv[0]  = '{32'hA1B2C3D4, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'h00,16'd0};
        tv[1]  = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'hA1,16'd0};
        tv[2]  = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'hB2,16'd1};
        tv[3]  = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'hC3,16'd2};
        tv[4]  = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'hD4,16'd3};
        tv[5]  = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,16'd4};
        tv[6]  = '{32'h01020304, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,16'd4};
        tv[7]  = '{32'h05060708, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h01,16'd4};
        tv[8]  = '{32'h05060708, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h02,16'd5};
        tv[9]  = '{32'h05060708, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h03,16'd6};
        tv[10] = '{32'h05060708, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,8'h04,16'd7};
        tv[11] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h05,16'd8};
        tv[12] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h06,16'd9};
        tv[13] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h07,16'd10};
        tv[14] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,8'h08,16'd11};
        tv[15] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,16'd0};
        tv[16] = '{32'h11223344, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,16'd0};
        tv[17] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h11,16'd0};
        tv[18] = '{32'h00000000, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h22,16'd1};
        tv[19] = '{32'h00000000, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h22,16'd1};
        tv[20] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h22,16'd1};
        tv[21] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h33,16'd2};
        tv[22] = '{32'h00000000, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h44,16'd3};
        tv[23] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'h44,16'd3};
        tv[24] = '{32'h00000000, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,16'd4};

        n_rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        m_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Vector table: single word, back-to-back frame, stalled output.
        for (int r = 0; r < 25; r++) begin
            in_data = tv[r].data; in_valid = tv[r].v; in_last = tv[r].l; out_ready = tv[r].ordy;
            #2;
            chk($sformatf("tv%0d_in_ready", r), {31'd0, in_ready}, {31'd0, tv[r].e_ir});
            chk($sformatf("tv%0d_out_valid", r), {31'd0, out_valid}, {31'd0, tv[r].e_ov});
            chk($sformatf("tv%0d_out_last", r), {31'd0, out_last}, {31'd0, tv[r].e_ol});
            if (tv[r].chk_pix)
                chk($sformatf("tv%0d_out_pix", r), {24'd0, out_pix}, {24'd0, tv[r].e_pix});
            chk($sformatf("tv%0d_pix_count", r), {16'd0, pix_count}, {16'd0, tv[r].e_cnt});
            tick();
        end

        // Reset after two pixels of a word: the rest must never appear.
        in_data = 32'hDEADBEEF; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_pix_before_rst", {24'd0, out_pix}, 32'h000000BE);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pix", {24'd0, out_pix}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pix_count", {16'd0, pix_count}, 32'd0);
        repeat (4) tick();

        // Input changes while not ready must be ignored.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55667788;
        tick();
        in_data = 32'h99AABBCC; tick();
        in_data = 32'h12345678; tick();
        out_ready = 1'b1;
        in_data = 32'hCAFEF00D; tick();
        tick(); tick();
        chk("hold_ignored_pix", {24'd0, out_pix}, 32'h00000088);
        in_data = 32'h0BADBEEF; tick();
        chk("late_accept_pix", {24'd0, out_pix}, 32'h0000000B);
        in_valid = 1'b0;
        repeat (5) tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_data   = $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            n_rst     = ($urandom_range(0, 199) != 0);
            tick();
        end
        n_rst = 1'b1;

        // Long frame without end marker: pix_count wraps through 65535 -> 0.
        n_rst = 1'b0; in_valid = 1'b0; tick();
        n_rst = 1'b1;
        in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 65536; c++) begin
            in_data = $urandom;
            tick();
        end
        chk("wrap_pre", {16'd0, pix_count}, 32'h0000FFFF);
        tick();
        chk("wrap_zero", {16'd0, pix_count}, 32'd0);
        tick();
        chk("wrap_continue", {16'd0, pix_count}, 32'd1);
        in_valid = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
